// File: rtl/pc_unit.sv
// Program counter with a circular return-address stack (RAS).
// Sequencing, jumps, calls and returns take effect one edge after capture.
module pc_unit #(
    parameter int WIDTH     = 13,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4   // legal range 2..16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcWrite,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        OP_SEQ  = 2'b00,
        OP_JUMP = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];

    logic [WIDTH-1:0] seq_pc;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             push_en;

    // top_q names the newest entry; the pointer wraps explicitly so any depth works.
    always_comb begin
        seq_pc  = pc_q + WIDTH'(STEP);
        top_inc = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
        top_dec = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);
    end

    always_comb begin
        pc_d    = pc_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (pcWrite) begin
            case (op_e'(op))
                OP_SEQ: begin
                    pc_d = seq_pc;
                end
                OP_JUMP: begin
                    pc_d = target;
                end
                OP_CALL: begin
                    // A full stack overwrites its oldest slot, which is the one after top.
                    pc_d    = target;
                    push_en = 1'b1;
                    top_d   = top_inc;
                    if (cnt_q == CNT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (cnt_q == '0) begin
                        pc_d  = seq_pc;
                        err_d = 1'b1;
                    end else begin
                        pc_d  = stack_q[top_q];
                        top_d = top_dec;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= WIDTH'(RESET_VEC);
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry storage is not reset: nothing reads it while the count is zero.
    always_ff @(posedge clk) begin
        if (push_en && rst) begin
            stack_q[top_inc] <= seq_pc;
        end
    end

    assign pc        = pc_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_MAX);
    assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every negedge,
// plus directed sequences with hand-computed expected values.
module tb_pc_unit;

  localparam int W = 13;
  localparam int DEPTH = 4;
  localparam logic [1:0] SEQ = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         pcWrite;
  logic [1:0]   op;
  logic [W-1:0] target;
  logic [W-1:0] pc;
  logic         ras_empty, ras_full, ras_err;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  pc_unit dut (
    .clk(clk), .rst(rst), .pcWrite(pcWrite), .op(op), .target(target),
    .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  // clock block
  always #5 clk = ~clk;

  // reference model: stack is a queue, newest entry at the back
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_stk[$];
  logic         m_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = '0;
      m_stk.delete();
      m_err = 1'b0;
    end else if (pcWrite) begin
      case (op)
        SEQ: m_pc = m_pc + 1;
        JMP: m_pc = target;
        CALL: begin
          m_stk.push_back(m_pc + 1);
          if (m_stk.size() > DEPTH) begin
            void'(m_stk.pop_front());
            m_err = 1'b1;
          end
          m_pc = target;
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_pc = m_pc + 1;
            m_err = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_empty", ras_empty, m_stk.size() == 0);
      check("model_full", ras_full, m_stk.size() == DEPTH);
      check("model_err", ras_err, m_err);
    end
  end

  // driver tasks
  task automatic cyc(input logic pw, input logic [1:0] o, input logic [W-1:0] t);
    pcWrite = pw;
    op = o;
    target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  int exp_ret[4] = '{41, 31, 21, 11};

  initial begin
    rst = 1'b0;
    pcWrite = 1'b0;
    op = SEQ;
    target = '0;
    #6;
    rst = 1'b1;
    chk_en = 1'b1;
    check("reset_pc", pc, 0);
    check("reset_empty", ras_empty, 1);
    check("reset_full", ras_full, 0);
    check("reset_err", ras_err, 0);

    // reset then sequential
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, SEQ, '0);
      check("seq_pc", pc, i);
    end
    check("seq_empty", ras_empty, 1);
    check("seq_err", ras_err, 0);

    // stall
    cyc(1'b1, JMP, 13'd105);
    check("jump_pc", pc, 105);
    repeat (4) cyc(1'b0, JMP, 13'd500);
    check("stall_pc", pc, 105);
    cyc(1'b1, JMP, 13'd500);
    check("unstall_pc", pc, 500);

    // nested call/return
    cyc(1'b1, JMP, 13'd10);
    cyc(1'b1, CALL, 13'd100);
    check("call1_pc", pc, 100);
    cyc(1'b1, CALL, 13'd200);
    check("call2_pc", pc, 200);
    cyc(1'b1, RET, '0);
    check("ret1_pc", pc, 101);
    cyc(1'b1, RET, '0);
    check("ret2_pc", pc, 11);
    check("nest_empty", ras_empty, 1);
    check("nest_err", ras_err, 0);

    // overflow
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, CALL, W'(10 * i));
    check("ovf_pc", pc, 50);
    check("ovf_full", ras_full, 1);
    check("ovf_err", ras_err, 1);
    cyc(1'b0, RET, '0);
    check("ovf_stall_pc", pc, 50);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, RET, '0);
      check("ovf_ret_pc", pc, exp_ret[i]);
    end
    check("ovf_drained", ras_empty, 1);
    cyc(1'b1, RET, '0);
    check("ovf_ret5_pc", pc, 12);

    // underflow and wrap
    do_reset();
    check("unf_err_clr", ras_err, 0);
    cyc(1'b1, JMP, 13'd8191);
    cyc(1'b1, SEQ, '0);
    check("wrap_pc", pc, 0);
    check("wrap_err", ras_err, 0);
    cyc(1'b1, RET, '0);
    check("unf_pc", pc, 1);
    check("unf_err", ras_err, 1);
    repeat (10) cyc(1'b1, SEQ, '0);
    check("unf_sticky", ras_err, 1);
    check("unf_pc_after", pc, 11);

    // async reset mid-stack
    do_reset();
    cyc(1'b1, JMP, 13'd50);
    cyc(1'b1, CALL, 13'd60);
    cyc(1'b1, CALL, 13'd70);
    check("arst_pre_pc", pc, 70);
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc", pc, 0);
    check("arst_empty", ras_empty, 1);
    check("arst_err", ras_err, 0);
    pcWrite = 1'b1;
    op = CALL;
    target = 13'd300;
    @(posedge clk);
    #1;
    check("arst_hold_pc", pc, 0);
    check("arst_hold_empty", ras_empty, 1);
    #1;
    rst = 1'b1;
    cyc(1'b1, RET, '0);
    check("arst_ret_pc", pc, 1);
    check("arst_ret_err", ras_err, 1);
    check("arst_ret_empty", ras_empty, 1);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 13: program-counter width in bits.
REQ-002 SHALL have parameter STEP, default 1: sequential increment.
REQ-003 SHALL have parameter RESET_VEC, default 0: PC value held during and after reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, legal range 2..16: return-address-stack entries.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port pcWrite, input, 1 bit: update enable; 0 means stall and hold all state.
REQ-008 SHALL have port op, input, 2 bits: 00 SEQ, 01 JUMP, 10 CALL, 11 RET.
REQ-009 SHALL have port target, input, WIDTH bits: destination for JUMP and CALL.
REQ-010 SHALL have port pc, output, WIDTH bits: registered current PC.
REQ-011 SHALL have port ras_empty, output, 1 bit: stack holds 0 entries.
REQ-012 SHALL have port ras_full, output, 1 bit: stack holds RAS_DEPTH entries.
REQ-013 SHALL have port ras_err, output, 1 bit: sticky flag for overflow or underflow.

Function
REQ-014 pc SHALL be a register; no combinational path from any input to pc.
REQ-015 pcWrite=0 SHALL hold pc, stack contents, count and ras_err regardless of op and target.
REQ-016 SEQ with pcWrite=1 SHALL set pc <= pc+STEP mod 2^WIDTH, with wrap-around and no flag.
REQ-017 JUMP with pcWrite=1 SHALL set pc <= target and leave the stack unchanged.
REQ-018 CALL with pcWrite=1 SHALL push (pc+STEP mod 2^WIDTH) onto the stack and set pc <= target in the same edge.
REQ-019 RET with pcWrite=1 and stack non-empty SHALL set pc <= the top entry and pop it in the same edge.
REQ-020 The stack SHALL be LIFO, implemented as a circular buffer with top pointer and count (0..RAS_DEPTH).
REQ-021 CALL when full SHALL overwrite the oldest entry (top advances, count stays RAS_DEPTH) and set ras_err.
REQ-022 RET when empty SHALL behave as SEQ (pc <= pc+STEP), leave count 0 and set ras_err.
REQ-023 ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH), both derived from registered count.
REQ-024 ras_err SHALL remain 1 until reset; no other clearing mechanism exists.
REQ-025 Latency SHALL be one cycle: the effect of op is visible on pc and flags after the capturing edge.

Reset
REQ-026 rst=0 SHALL immediately force pc=RESET_VEC, count=0, top=0, ras_err=0, ras_empty=1, ras_full=0, independent of clk.
REQ-027 Stack entry storage SHALL not require reset; contents are unreachable while count=0.
REQ-028 Reset asserted mid-operation (including during a CALL/RET edge) SHALL win; the first update occurs on the first rising clk edge after rst returns to 1.
REQ-029 While rst=0, pcWrite and op SHALL be ignored.

Verification
REQ-030 Reset/SEQ: rst=0 for 6 ns, then pcWrite=1, op=SEQ for 3 edges -> pc goes 0,1,2,3; ras_empty=1, ras_err=0.
REQ-031 Stall: pc=105, pcWrite=0, op=JUMP, target=500 for 4 edges -> pc stays 105; one edge with pcWrite=1 -> pc=500.
REQ-032 Nested call/return: pc=10, CALL 100; pc=100, CALL 200; RET; RET -> pc sequence 100, 200, 101, 11; empty at end, ras_err=0.
REQ-033 Overflow: with RAS_DEPTH=4, 5 CALLs from pcs 0,10,20,30,40 -> ras_full=1, ras_err=1; 4 RETs return 41,31,21,11; a 5th RET acts as SEQ.
REQ-034 Underflow and wrap: pc=8191 (WIDTH=13), SEQ -> pc=0; RET on empty stack -> pc=1, ras_err=1, which stays 1 through 10 further edges.
REQ-035 Async reset mid-stack: 2 CALLs, rst=0 asserted between clk edges -> pc=RESET_VEC and ras_empty=1 before the next edge; a following RET acts as SEQ and sets ras_err.
